// File: rtl/dpram_rd_pkg.sv
// Shared definitions for the dual-port RAM stream reader: the controller
// state encoding, the default bus widths and the read-FIFO entry layout.
package dpram_rd_pkg;

    // Default widths of the RAM read port and of the output stream.
    localparam int ADR_WIDTH_DEF = 13;
    localparam int DAT_WIDTH_DEF = 16;

    // Output buffer: two words are enough to keep one read per cycle
    // flowing while absorbing a single cycle of consumer back-pressure.
    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W = 1;
    localparam int FIFO_OCC_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    // One buffered word plus the flag marking the final word of a command.
    // The data field is sized for DAT_WIDTH_DEF; instances of the reader
    // must use that data width.
    typedef struct packed {
        logic                     last;
        logic [DAT_WIDTH_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/dpram_stream_reader_if.sv
// Bundle of the command, RAM read-port and output-stream signals of the
// stream reader. The reader itself uses the master view; the environment
// (RAM, command source and stream consumer) uses the slave view.
interface dpram_stream_reader_if
    import dpram_rd_pkg::*;
#(
    parameter int ADR_WIDTH = ADR_WIDTH_DEF,
    parameter int DAT_WIDTH = DAT_WIDTH_DEF
);

    // Command channel
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADR_WIDTH-1:0] cmd_base;
    logic [ADR_WIDTH:0]   cmd_len;

    // RAM read port
    logic                 mem_en;
    logic                 mem_re;
    logic [ADR_WIDTH-1:0] mem_adr;
    logic [DAT_WIDTH-1:0] mem_dat;

    // Output stream
    logic                 m_valid;
    logic                 m_ready;
    logic [DAT_WIDTH-1:0] m_data;
    logic                 m_last;

    // Status
    logic                 busy;
    logic                 done;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, mem_dat, m_ready,
        output cmd_ready, mem_en, mem_re, mem_adr,
               m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, mem_dat, m_ready,
        input  cmd_ready, mem_en, mem_re, mem_adr,
               m_valid, m_data, m_last, busy, done
    );

endinterface

// File: rtl/sync_fifo2.sv
// Two-entry synchronous FIFO holding words returned by the RAM until the
// stream consumer takes them. Push and pop may happen in the same cycle,
// including when the FIFO is full (the popped slot is reused).
module sync_fifo2
    import dpram_rd_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  fifo_entry_t           push_data,
    input  logic                  pop,
    output fifo_entry_t           head,
    output logic [FIFO_OCC_W-1:0] occ,
    output logic                  empty,
    output logic                  full
);

    fifo_entry_t             mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_OCC_W-1:0]   occ_q, occ_d;
    logic                    do_push;
    logic                    do_pop;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == FIFO_OCC_W'(FIFO_DEPTH));
    assign occ   = occ_q;
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO only accepts a word when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy bookkeeping for the next cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Register pointers and occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage slots; each slot loads only when the write pointer selects it.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        fifo_entry_t entry_d;

        // Next value of this slot.
        always_comb begin
            entry_d = mem_q[gi];
            if (do_push && (wr_ptr_q == FIFO_PTR_W'(gi))) begin
                entry_d = push_data;
            end
        end

        // Slot register; cleared so the stream outputs read zero after reset.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= entry_d;
            end
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// Read-side master for the dual-port RAM. Accepts a (base, length) command,
// walks the RAM read port from base upwards (wrapping at the top of the
// address space) and presents the returned words as a valid/ready stream,
// flagging the final word with m_last and pulsing done when it is taken.
module dpram_stream_reader
    import dpram_rd_pkg::*;
#(
    parameter int ADR_WIDTH = ADR_WIDTH_DEF,
    parameter int DAT_WIDTH = DAT_WIDTH_DEF
)
(
    input  logic                   clk,
    input  logic                   resetn,
    dpram_stream_reader_if.master  bus
);

    localparam logic [ADR_WIDTH:0] REM_ONE = (ADR_WIDTH + 1)'(1);

    state_t                 state_q, state_d;
    logic [ADR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADR_WIDTH:0]     remaining_q, remaining_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;

    fifo_entry_t            fifo_head;
    fifo_entry_t            fifo_push_data;
    logic [FIFO_OCC_W-1:0]  fifo_occ;
    logic                   fifo_empty;
    logic                   fifo_full;

    logic                   m_valid;
    logic                   pop;
    logic [2:0]             held_words;
    logic [2:0]             held_limit;
    logic                   issue;
    logic                   final_issue;

    assign m_valid = ~fifo_empty;
    assign pop     = m_valid & bus.m_ready;

    // Words already committed to the consumer side: buffered plus the one
    // coming back from the RAM. A word leaving this cycle frees its slot
    // immediately, which gives the deliberate m_ready -> mem_en path.
    assign held_words  = {1'b0, fifo_occ} + {2'b00, inflight_q};
    assign held_limit  = 3'd2 + {2'b00, pop};
    assign issue       = (state_q == RUN) && (remaining_q != '0) && (held_words < held_limit);
    assign final_issue = issue && (remaining_q == REM_ONE);

    // Controller, address walker and remaining-count next-state logic.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = final_issue;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_base;
                    remaining_d = bus.cmd_len;
                    state_d     = (bus.cmd_len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final word may still be in flight; wait for it to be taken.
                if (pop && fifo_head.last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state, counters and the in-flight read tracker.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // RAM data is valid the cycle after a read is issued; capture it then.
    assign fifo_push_data = '{last: inflight_last_q, data: bus.mem_dat};

    sync_fifo2 u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight_q),
        .push_data (fifo_push_data),
        .pop       (pop),
        .head      (fifo_head),
        .occ       (fifo_occ),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
    assign bus.mem_en    = issue;
    assign bus.mem_re    = issue;
    assign bus.mem_adr   = addr_q;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = fifo_head.data;
    assign bus.m_last    = fifo_head.last;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed + randomized bench for dpram_stream_reader. A behavioural RAM
// answers reads one cycle late; expected stream contents come straight from
// the RAM image: word i of a command is ram[(base + i) mod 2^AW].
module tb_dpram_stream_reader;

    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int MASK  = DEPTH - 1;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] ram [DEPTH];

    dpram_stream_reader_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

    dpram_stream_reader #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // RAM read port with one cycle of latency.
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            bus.mem_dat <= ram[bus.mem_adr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input bit adr_zero);
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, " busy"},      32'(bus.busy),      32'd0);
        check({tag, " done"},      32'(bus.done),      32'd0);
        check({tag, " mem_en"},    32'(bus.mem_en),    32'd0);
        check({tag, " mem_re"},    32'(bus.mem_re),    32'd0);
        check({tag, " m_valid"},   32'(bus.m_valid),   32'd0);
        check({tag, " m_last"},    32'(bus.m_last),    32'd0);
        if (adr_zero) begin
            check({tag, " m_data"},  32'(bus.m_data),  32'd0);
            check({tag, " mem_adr"}, 32'(bus.mem_adr), 32'd0);
        end
    endtask

    // m_ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one command from handshake to cmd_ready returning. Starts and
    // ends just after a rising edge; cycle 0 is the handshake cycle.
    task automatic do_cmd(input logic [AW-1:0] base, input int len, input int mode, input string name);
        int            issued   = 0;
        int            popped   = 0;
        int            done_cyc = -1;
        int            first_en = -1;
        int            first_v  = -1;
        int            budget   = 4 * len + 40;
        bit            stalled  = 1'b0;
        bit            finished = 1'b0;
        logic [DW-1:0] held_d   = '0;
        logic          held_l   = 1'b0;
        bus.cmd_base  = base;
        bus.cmd_len   = (AW + 1)'(len);
        bus.cmd_valid = 1'b1;
        bus.m_ready   = ready_for(mode, 0);
        @(negedge clk);
        check({name, " cmd_ready@0"}, 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
            bus.m_ready = ready_for(mode, cyc);
            @(negedge clk);
            check({name, " mem_re==mem_en"}, 32'(bus.mem_re), 32'(bus.mem_en));
            if (bus.mem_en === 1'b1) begin
                check($sformatf("%s mem_adr#%0d", name, issued), 32'(bus.mem_adr),
                      32'((int'(base) + issued) & MASK));
                if (first_en < 0) first_en = cyc;
                issued++;
                check({name, " reads<=len"}, 32'(issued <= len), 32'd1);
            end
            if (stalled) begin
                check({name, " stall m_valid"}, 32'(bus.m_valid), 32'd1);
                check({name, " stall m_data"},  32'(bus.m_data),  32'(held_d));
                check({name, " stall m_last"},  32'(bus.m_last),  32'(held_l));
            end
            if (bus.m_valid === 1'b1 && first_v < 0) first_v = cyc;
            if (bus.m_valid === 1'b1 && bus.m_ready) begin
                check($sformatf("%s m_data#%0d", name, popped), 32'(bus.m_data),
                      32'(ram[(int'(base) + popped) & MASK]));
                check($sformatf("%s m_last#%0d", name, popped), 32'(bus.m_last),
                      32'(popped == len - 1));
                popped++;
            end
            stalled = (bus.m_valid === 1'b1) && !bus.m_ready;
            held_d  = bus.m_data;
            held_l  = bus.m_last;
            check({name, " held<=2"}, 32'((issued - popped) <= 2), 32'd1);
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({name, " cmd_ready after done"}, 32'(bus.cmd_ready), 32'd1);
                check({name, " busy after done"},      32'(bus.busy),      32'd0);
                check({name, " done one cycle"},       32'(bus.done),      32'd0);
                finished = 1'b1;
            end else begin
                check({name, " cmd_ready while busy"}, 32'(bus.cmd_ready), 32'd0);
                check({name, " busy"},                 32'(bus.busy),      32'd1);
                if (bus.done === 1'b1) begin
                    check({name, " words before done"}, 32'(popped), 32'(len));
                    done_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
        end
        check({name, " completed in budget"}, 32'(finished), 32'd1);
        check({name, " total reads"}, 32'(issued), 32'(len));
        check({name, " total words"}, 32'(popped), 32'(len));
        if (mode == 0) begin
            check({name, " first mem_en cycle"},  32'(first_en), 32'((len > 0) ? 1 : -1));
            check({name, " first m_valid cycle"}, 32'(first_v),  32'((len > 0) ? 3 : -1));
            check({name, " done cycle"},          32'(done_cyc), 32'((len > 0) ? len + 3 : 1));
        end
        $display("cmd %s base=0x%0h len=%0d mode=%0d reads=%0d words=%0d done@%0d",
                 name, base, len, mode, issued, popped, done_cyc);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b0;
        for (int a = 0; a < DEPTH; a++) ram[a] = DW'(a + 'h100);

        // Reset values, during and after reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("in reset", 1'b1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_idle("after release", 1'b1);
        @(posedge clk);
        #1;

        // Reset in cycle 5 of a 20-word command aborts it without done.
        bus.cmd_base  = 13'h0040;
        bus.cmd_len   = 14'd20;
        bus.cmd_valid = 1'b1;
        bus.m_ready   = 1'b1;
        @(negedge clk);
        check("abort cmd_ready@0", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("abort busy@%0d", c), 32'(bus.busy), 32'd1);
            check($sformatf("abort done@%0d", c), 32'(bus.done), 32'd0);
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        @(negedge clk);
        check_idle("abort reset@5", 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("abort reset@6", 1'b1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_idle("abort released", 1'b1);
        @(posedge clk);
        #1;
        $display("txn abort: reset during 20-word command");

        // Directed commands with m_ready held high.
        do_cmd(13'h0010, 4, 0, "base010");
        do_cmd(13'h1FFE, 4, 0, "wrap1FFE");
        do_cmd(13'h0123, 0, 0, "len0");

        // len=0 with cmd_valid held through the busy period.
        bus.cmd_base  = 13'h00AA;
        bus.cmd_len   = '0;
        bus.cmd_valid = 1'b1;
        bus.m_ready   = 1'b1;
        @(negedge clk);
        check("hold c0 cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold c1 cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("hold c1 done",      32'(bus.done),      32'd1);
        check("hold c1 mem_en",    32'(bus.mem_en),    32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("hold c2 cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("hold c2 done",      32'(bus.done),      32'd0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("hold c3 busy",      32'(bus.busy),      32'd1);
        check("hold c3 done",      32'(bus.done),      32'd1);
        check("hold c3 cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_idle("hold c4", 1'b0);
        @(posedge clk);
        #1;
        $display("txn hold: len=0 with cmd_valid held, accepted again in cycle 2");

        // Random RAM image from here on.
        for (int a = 0; a < DEPTH; a++) ram[a] = DW'($urandom);

        do_cmd(AW'($urandom), 8, 1, "toggle8");
        for (int k = 0; k < 6; k++) begin
            do_cmd(AW'($urandom), int'($urandom_range(1, 24)), 2, $sformatf("rand%0d", k));
        end
        do_cmd(13'h1FF0, 5, 2, "randwrap");
        do_cmd(AW'($urandom), DEPTH, 0, "full8192");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
